// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default parameters for the pulse_stretcher block.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_e;

  localparam int DEF_WIDTH_W = 8;
  localparam int DEF_MIN_GAP = 2;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Strobe-in / level-out bundle for pulse_stretcher; master drives strobes, slave is the stretcher.
interface pulse_stretcher_if
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH_W = DEF_WIDTH_W,
  parameter int CNT_W   = DEF_CNT_W
) ();

  logic               pulse_in;
  logic [WIDTH_W-1:0] width;
  logic               clr_overrun;
  logic               level_out;
  logic               busy;
  logic               overrun;
  logic [CNT_W-1:0]   accept_cnt;

  modport master (
    output pulse_in, width, clr_overrun,
    input  level_out, busy, overrun, accept_cnt
  );

  modport slave (
    input  pulse_in, width, clr_overrun,
    output level_out, busy, overrun, accept_cnt
  );

endinterface

// File: rtl/pulse_stretch_timer.sv
// Loadable down-counter; expire is high during the last counted cycle (count == 1).
module pulse_stretch_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle strobes into timed level pulses followed by a MIN_GAP low gap.
// Define PULSE_STRETCHER_RETRIGGER_EN to accept (and reload on) strobes during an active pulse.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH_W = DEF_WIDTH_W,
  parameter int MIN_GAP = DEF_MIN_GAP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  pulse_stretcher_if.slave bus
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  state_e             state_q, state_d;
  logic               level_q, level_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_W-1:0] load_len;
  logic               ovr_set;
  logic               len_load, len_dec, len_expire;
  logic               gap_load, gap_dec, gap_expire;

  pulse_stretch_timer #(.W(WIDTH_W)) u_len_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (len_load),
    .load_val (load_len),
    .dec_en   (len_dec),
    .expire   (len_expire)
  );

  pulse_stretch_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(MIN_GAP)),
    .dec_en   (gap_dec),
    .expire   (gap_expire)
  );

  always_comb begin
    load_len = (bus.width == '0) ? WIDTH_W'(1) : bus.width;
    state_d  = state_q;
    level_d  = level_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    ovr_set  = 1'b0;
    len_load = 1'b0;
    len_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          len_load = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          level_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        len_dec = 1'b1;
        // A retrigger outranks expiry, even on the final high cycle.
        if (bus.pulse_in && RETRIG) begin
          len_load = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          ovr_set = bus.pulse_in;
          if (len_expire) begin
            level_d = 1'b0;
            if (MIN_GAP > 0) begin
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        gap_dec = 1'b1;
        ovr_set = bus.pulse_in;
        if (gap_expire) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        level_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A new drop outranks a clear in the same cycle.
    ovr_d = ovr_set | (ovr_q & ~bus.clr_overrun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = ovr_q;
  assign bus.accept_cnt = cnt_q;

endmodule
